// File: rtl/access_controller.sv
// Parking-gate access controller: PIN entry, gate sequencing, wrong-PIN and tailgating alarms.
// Optional WAIT_PIN entry timeout is compiled in when ACCESS_TIMEOUT_EN is defined.
module access_controller #(
    parameter logic [7:0] PIN_CODE       = 8'h35,
    parameter int         MAX_TRIES      = 3,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_arrive,
    input  logic       sensor_parked,
    input  logic       pin_valid,
    input  logic [7:0] pin,
    output logic       gate_open,
    output logic       gate_close,
    output logic       alarm_pin,
    output logic       alarm_block
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PIN,
        OPEN,
        CLOSING,
        BLOCKED
    } state_e;

    localparam int               TRY_W   = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    state_e           state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             alarm_pin_q, alarm_pin_d;
    logic             pin_ok, pin_bad;
    logic             timeout_hit;

    assign pin_ok  = pin_valid && (pin == PIN_CODE);
    assign pin_bad = pin_valid && (pin != PIN_CODE);

`ifdef ACCESS_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Fires on the last of TIMEOUT_CYCLES consecutive strobe-free cycles in WAIT_PIN.
    assign timeout_hit = (state_q == WAIT_PIN) && !pin_valid && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_PIN && !pin_valid && !timeout_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    // No timeout hardware: WAIT_PIN waits forever, and this compare folds to constant 0.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: every signal gets its hold value before the case, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tries_d     = tries_q;
        alarm_pin_d = alarm_pin_q;

        case (state_q)
            IDLE: begin
                if (sensor_arrive) begin
                    state_d = WAIT_PIN;
                    tries_d = '0;
                end
            end

            WAIT_PIN: begin
                if (pin_ok) begin
                    state_d     = OPEN;
                    tries_d     = '0;
                    alarm_pin_d = 1'b0;
                end else if (pin_bad) begin
                    if (tries_q != TRY_MAX) begin
                        tries_d = tries_q + 1'b1;
                    end
                    if (tries_d == TRY_MAX) begin
                        alarm_pin_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    tries_d     = '0;
                    alarm_pin_d = 1'b0;
                end
            end

            OPEN: begin
                // A second vehicle at the entrance while the first clears the gate is tailgating.
                if (sensor_parked && sensor_arrive) begin
                    state_d = BLOCKED;
                end else if (sensor_parked) begin
                    state_d = CLOSING;
                end
            end

            CLOSING: begin
                state_d = IDLE;
            end

            BLOCKED: begin
                if (pin_ok) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tries_q     <= '0;
            alarm_pin_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            alarm_pin_q <= alarm_pin_d;
        end
    end

    assign gate_open   = (state_q == OPEN);
    assign gate_close  = (state_q == CLOSING) || (state_q == BLOCKED);
    assign alarm_block = (state_q == BLOCKED);
    assign alarm_pin   = alarm_pin_q;

endmodule

// File: tb/tb_access_controller.sv
// Scoreboard bench for access_controller: each vector pushes its expected outputs,
// which are popped and compared one clock later.
module tb_access_controller;

    localparam logic [7:0] GOOD = 8'h35;
    localparam logic [7:0] BAD  = 8'h12;

    // Expected {gate_open, gate_close, alarm_pin, alarm_block}
    localparam logic [3:0] O_NONE  = 4'b0000;
    localparam logic [3:0] O_OPEN  = 4'b1000;
    localparam logic [3:0] O_CLOSE = 4'b0100;
    localparam logic [3:0] O_ALARM = 4'b0010;
    localparam logic [3:0] O_BLOCK = 4'b0101;

    typedef struct packed {
        logic       rst;
        logic       arrive;
        logic       parked;
        logic       pv;
        logic [7:0] pin;
        logic [3:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sensor_arrive;
    logic       sensor_parked;
    logic       pin_valid;
    logic [7:0] pin;
    logic       gate_open;
    logic       gate_close;
    logic       alarm_pin;
    logic       alarm_block;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] sb[$];

    always #5 clk = ~clk;

    access_controller dut (
        .clk           (clk),
        .reset         (reset),
        .sensor_arrive (sensor_arrive),
        .sensor_parked (sensor_parked),
        .pin_valid     (pin_valid),
        .pin           (pin),
        .gate_open     (gate_open),
        .gate_close    (gate_close),
        .alarm_pin     (alarm_pin),
        .alarm_block   (alarm_block)
    );

    function automatic vec_t mk(input logic r, input logic a, input logic p, input logic v,
                                input logic [7:0] pn, input logic [3:0] e);
        vec_t t;
        t.rst    = r;
        t.arrive = a;
        t.parked = p;
        t.pv     = v;
        t.pin    = pn;
        t.exp    = e;
        return t;
    endfunction

    // Drive one vector, record its expectation, and advance to the next falling edge.
    task automatic apply(input vec_t t);
        reset         = t.rst;
        sensor_arrive = t.arrive;
        sensor_parked = t.parked;
        pin_valid     = t.pv;
        pin           = t.pin;
        sb.push_back(t.exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t       v[$];
        logic [3:0] got, want;
        v.push_back(mk(1, 1, 1, 1, GOOD, O_NONE));
        v.push_back(mk(1, 0, 1, 1, BAD,  O_NONE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_correct_entry();
        vec_t       v[$];
        logic [3:0] got, want;
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));   // IDLE -> WAIT_PIN
        v.push_back(mk(0, 0, 0, 0, GOOD,  O_NONE));   // PIN without strobe is ignored
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_OPEN));   // arrive alone keeps OPEN
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_NONE));   // CLOSING lasts one cycle
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_NONE));   // PIN in IDLE does nothing
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL correct_entry[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_wrong_pin();
        vec_t       v[$];
        logic [3:0] got, want;
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));   // try 1
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));   // try 2
        v.push_back(mk(0, 0, 0, 1, BAD,   O_ALARM));  // try 3 raises alarm
        v.push_back(mk(0, 0, 0, 0, GOOD,  O_ALARM));  // held without strobe
        v.push_back(mk(0, 0, 0, 1, 8'h00, O_ALARM));  // saturated
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));   // correct PIN clears alarm
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));   // counter must restart at zero
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_ALARM));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL wrong_pin[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_tailgate();
        vec_t       v[$];
        logic [3:0] got, want;
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 1, 1, 0, 8'h00, O_BLOCK));  // tailgating beats plain parked
        v.push_back(mk(0, 0, 0, 1, 8'h00, O_BLOCK));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_BLOCK));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_BLOCK));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_BLOCK));  // no pin alarm from BLOCKED
        v.push_back(mk(0, 0, 1, 0, GOOD,  O_BLOCK));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_NONE));   // only a correct PIN releases
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL tailgate[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        vec_t       v[$];
        logic [3:0] got, want;
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(1, 0, 1, 0, 8'h00, O_NONE));   // reset in OPEN
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 1, 1, 0, 8'h00, O_BLOCK));
        v.push_back(mk(1, 0, 0, 1, GOOD,  O_NONE));   // reset in BLOCKED
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_ALARM));
        v.push_back(mk(1, 1, 0, 1, GOOD,  O_NONE));   // reset drops alarm_pin
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    task automatic test_timeout();
        vec_t       v[$];
        logic [3:0] got, want;
`ifdef ACCESS_TIMEOUT_EN
        // 15 quiet cycles: still waiting, correct PIN opens.
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        for (int k = 0; k < 15; k++) v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        // 16 quiet cycles: back in IDLE, PIN ignored.
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        for (int k = 0; k < 16; k++) v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_NONE));
        // Timeout also clears a raised alarm_pin.
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_ALARM));
        for (int k = 0; k < 15; k++) v.push_back(mk(0, 0, 0, 0, 8'h00, O_ALARM));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_NONE));
`else
        // No timeout: alarm and WAIT_PIN persist through 100 quiet cycles.
        v.push_back(mk(0, 1, 0, 0, 8'h00, O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_NONE));
        v.push_back(mk(0, 0, 0, 1, BAD,   O_ALARM));
        for (int k = 0; k < 100; k++) v.push_back(mk(0, 0, 0, 0, 8'h00, O_ALARM));
        v.push_back(mk(0, 0, 0, 1, GOOD,  O_OPEN));
        v.push_back(mk(0, 0, 1, 0, 8'h00, O_CLOSE));
        v.push_back(mk(0, 0, 0, 0, 8'h00, O_NONE));
`endif
        foreach (v[i]) begin
            apply(v[i]);
            want = sb.pop_front();
            got  = {gate_open, gate_close, alarm_pin, alarm_block};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, got, want);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        sensor_arrive = 1'b0;
        sensor_parked = 1'b0;
        pin_valid     = 1'b0;
        pin           = 8'h00;
        test_reset();
        test_correct_entry();
        test_wrong_pin();
        test_tailgate();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/access_controller.md
ACCESS_CONTROLLER -- requirements
Module: access_controller

Interface
REQ-001 The block SHALL have parameter PIN_CODE, default 8'h35, the correct access PIN.
REQ-002 The block SHALL have parameter MAX_TRIES, default 3, the wrong-PIN count that raises alarm_pin.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, the PIN-entry timeout (used only with ACCESS_TIMEOUT_EN).
REQ-004 Ports SHALL be:
  clk            input   1  single clock; all state changes on rising edge
  reset          input   1  synchronous, active-high reset
  sensor_arrive  input   1  vehicle present at entrance
  sensor_parked  input   1  vehicle has passed the gate
  pin_valid      input   1  one-cycle strobe; pin is sampled when high
  pin            input   8  entered PIN
  gate_open      output  1  gate open command
  gate_close     output  1  gate close command
  alarm_pin      output  1  wrong-PIN alarm
  alarm_block    output  1  tailgating/block alarm
REQ-005 The design SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 The FSM SHALL have states IDLE, WAIT_PIN, OPEN, CLOSING and BLOCKED, held in a state register.
REQ-007 Outputs SHALL be Moore outputs decoded from the state register, plus the alarm_pin flop, so each changes in the cycle after the triggering input edge.
REQ-008 IDLE: sensor_arrive=1 -> WAIT_PIN, wrong-try counter cleared; otherwise stay.
REQ-009 WAIT_PIN: pin_valid=1 and pin==PIN_CODE -> OPEN, counter cleared, alarm_pin cleared.
REQ-010 WAIT_PIN: pin_valid=1 and pin!=PIN_CODE -> stay; counter increments, saturating at MAX_TRIES.
REQ-011 alarm_pin SHALL set in the cycle after the counter reaches MAX_TRIES; it SHALL stay high until a correct PIN or reset.
REQ-012 WAIT_PIN with pin_valid=0 SHALL hold state, counter and alarm_pin.
REQ-013 OPEN: gate_open=1; sensor_parked=1 with sensor_arrive=0 -> CLOSING.
REQ-014 OPEN: sensor_parked=1 and sensor_arrive=1 in the same cycle (tailgating) -> BLOCKED; this SHALL take priority over REQ-013.
REQ-015 CLOSING: gate_close=1 for exactly one cycle, then IDLE unconditionally.
REQ-016 BLOCKED: gate_close=1 and alarm_block=1; only pin_valid=1 with pin==PIN_CODE -> IDLE; wrong PINs SHALL be ignored without changing the counter.
REQ-017 gate_open and gate_close SHALL never both be 1.
REQ-018 The RTL SHALL synthesize with Yosys onto the team's cell library (BUF, NOT, NAND, NOR, reset-less DFF) with no latches and no asynchronous logic.

Reset
REQ-019 reset=1 at a rising edge SHALL force state IDLE, counter 0, timeout counter 0, and all outputs 0 in the next cycle, regardless of state or simultaneous inputs.
REQ-020 Reset asserted mid-operation, including OPEN or BLOCKED, SHALL drop gate_open and both alarms on the next edge.

Configuration
REQ-021 With macro ACCESS_TIMEOUT_EN defined, a counter SHALL run in WAIT_PIN and clear on every pin_valid.
REQ-022 With ACCESS_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES consecutive cycles without pin_valid SHALL return WAIT_PIN to IDLE with the counter, wrong-try counter and alarm_pin cleared.
REQ-023 With ACCESS_TIMEOUT_EN not defined, WAIT_PIN SHALL wait indefinitely and no timeout flops SHALL be synthesized.

Verification
REQ-024 Correct entry: reset, sensor_arrive=1, then pin_valid=1 with pin=8'h35 -> gate_open=1 the next cycle; then sensor_parked=1 -> gate_close=1 for 1 cycle, then IDLE with all outputs 0.
REQ-025 Wrong PIN: in WAIT_PIN, three pin_valid strobes with pin=8'h12 -> alarm_pin=1 after the third; a fourth strobe with pin=8'h35 -> alarm_pin=0 and gate_open=1.
REQ-026 Tailgating: in OPEN, sensor_arrive=1 and sensor_parked=1 together -> gate_close=1 and alarm_block=1; pin=8'h00 keeps BLOCKED; pin=8'h35 -> IDLE, outputs 0.
REQ-027 Reset mid-operation: reset=1 for one cycle while in BLOCKED or OPEN -> all outputs 0 next cycle, and the FSM accepts a new sensor_arrive.
REQ-028 Timeout (ACCESS_TIMEOUT_EN defined): enter WAIT_PIN and idle 16 cycles -> back in IDLE; without the macro -> still in WAIT_PIN after 100 cycles.
REQ-029 Gate-level check: the Yosys netlist mapped to the cell library SHALL match the RTL outputs cycle-for-cycle on REQ-024 through REQ-027.
